// File: rtl/z80_bus_pkg.sv
// z80_bus_pkg: shared definitions for the Z80 I/O cycle master.
//   - T-state encoding (IDLE, T1, T2, TW, T3), both as an enum and as plain
//     3-bit constants for legacy-style state registers.
//   - CPC gate-array I/O port address and the RAM bank-select data prefix
//     (top two data bits 2'b11 select the RAM banking register).
package z80_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_TW   = 3'd3,
        S_T3   = 3'd4
    } bus_state_e;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_T1   = 3'd1;
    localparam logic [2:0] ST_T2   = 3'd2;
    localparam logic [2:0] ST_TW   = 3'd3;
    localparam logic [2:0] ST_T3   = 3'd4;

    localparam logic [15:0] GA_PORT         = 16'h7F00;
    localparam logic [1:0]  RAM_BANK_PREFIX = 2'b11;

endpackage

// File: rtl/z80_io_cycle_master_if.sv
// z80_io_cycle_master_if: host handshake plus Z80 expansion-bus pins.
//   Host side : req, rnw, addr, wdata (to master); done, rdata, busy, timeout (from master)
//   Bus side  : a, d_out, d_oe, iorq_b, rd_b, wr_b, mreq_b, m1_b (from master);
//               d_in, wait_b (to master)
//   modport master : the cycle generator's view
//   modport slave  : the host / expansion-bus view
interface z80_io_cycle_master_if;
    logic        req;
    logic        rnw;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        done;
    logic [7:0]  rdata;
    logic        busy;
    logic        timeout;
    logic [15:0] a;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [7:0]  d_in;
    logic        iorq_b;
    logic        rd_b;
    logic        wr_b;
    logic        mreq_b;
    logic        m1_b;
    logic        wait_b;

    modport master (
        input  req, rnw, addr, wdata, d_in, wait_b,
        output done, rdata, busy, timeout, a, d_out, d_oe,
               iorq_b, rd_b, wr_b, mreq_b, m1_b
    );

    modport slave (
        output req, rnw, addr, wdata, d_in, wait_b,
        input  done, rdata, busy, timeout, a, d_out, d_oe,
               iorq_b, rd_b, wr_b, mreq_b, m1_b
    );
endinterface

// File: rtl/z80_wait_counter.sv
// z80_wait_counter: wait-state bookkeeping for the TW state.
//   Optional feature macro: WAIT_TIMEOUT_EN (consecutive external-wait timeout).
//   Ports:
//     clock, resetb : bus clock, asynchronous active-low reset
//     clear         : clear both counters (T1 entry)
//     in_tw         : the master is in TW this cycle
//     wait_b        : sampled active-low WAIT
//     forced_done   : EXTRA_WAIT forced waits (wait_b=1 cycles) have elapsed
//     timeout_hit   : this TW cycle is the WAIT_MAX-th consecutive wait_b=0 sample
module z80_wait_counter #(
    parameter int EXTRA_WAIT = 0,
    parameter int WAIT_MAX   = 255,
    parameter int CNT_W      = 8
) (
    input  logic clock,
    input  logic resetb,
    input  logic clear,
    input  logic in_tw,
    input  logic wait_b,
    output logic forced_done,
    output logic timeout_hit
);

    localparam logic [3:0] FORCED_LAST = 4'(EXTRA_WAIT);

    logic [3:0] forced_cnt_r;

    // Forced waits only accumulate on TW cycles where the expansion is ready,
    // so external and forced waits add rather than overlap.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            forced_cnt_r <= 4'd0;
        end else if (clear) begin
            forced_cnt_r <= 4'd0;
        end else if (in_tw && wait_b && (forced_cnt_r != FORCED_LAST)) begin
            forced_cnt_r <= forced_cnt_r + 4'd1;
        end
    end

    assign forced_done = (forced_cnt_r == FORCED_LAST);

`ifdef WAIT_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

    logic [CNT_W-1:0] wait_cnt_r;

    // Counts consecutive wait_b=0 samples in TW; a ready sample restarts the run.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            wait_cnt_r <= {CNT_W{1'b0}};
        end else if (in_tw) begin
            if (!wait_b) begin
                if (wait_cnt_r != {CNT_W{1'b1}}) begin
                    wait_cnt_r <= wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                wait_cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

    // The current low sample is the WAIT_MAX-th when WAIT_MAX-1 are already counted.
    assign timeout_hit = in_tw && !wait_b && (wait_cnt_r >= WAIT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: rtl/z80_io_cycle_master.sv
// z80_io_cycle_master: Z80-style IN/OUT bus cycle initiator (T1, T2, TW.., T3).
//   Optional feature macro: WAIT_TIMEOUT_EN (timeout after WAIT_MAX consecutive
//   external waits; forces T3, sets sticky timeout, reads return 8'hFF).
//   Ports:
//     clock  : bus clock, all state changes on posedge
//     resetb : asynchronous active-low reset (aborts a cycle without done)
//     bus    : z80_io_cycle_master_if.master - host handshake and Z80 pins
//   Parameters: EXTRA_WAIT (forced waits after the automatic TW), WAIT_MAX,
//   CNT_W (wait counter width, 2**CNT_W > WAIT_MAX).
module z80_io_cycle_master
    import z80_bus_pkg::*;
#(
    parameter int EXTRA_WAIT = 0,
    parameter int WAIT_MAX   = 255,
    parameter int CNT_W      = 8
) (
    input  logic                         clock,
    input  logic                         resetb,
    z80_io_cycle_master_if.master        bus
);

    logic [2:0]  state_r;
    logic [2:0]  state_nx_s;
    logic        rnw_r;
    logic [15:0] a_r;
    logic [7:0]  d_out_r;
    logic        d_oe_r;
    logic        iorq_b_r;
    logic        rd_b_r;
    logic        wr_b_r;
    logic        done_r;
    logic        busy_r;
    logic [7:0]  rdata_r;
    logic [7:0]  rd_val_s;
    logic        start_s;
    logic        in_tw_s;
    logic        forced_done_s;
    logic        timeout_hit_s;
    logic        timed_out_s;

    // A new cycle starts from IDLE or directly from T3 (back-to-back).
    assign start_s = bus.req && ((state_r == ST_IDLE) || (state_r == ST_T3));
    assign in_tw_s = (state_r == ST_TW);

    z80_wait_counter #(
        .EXTRA_WAIT (EXTRA_WAIT),
        .WAIT_MAX   (WAIT_MAX),
        .CNT_W      (CNT_W)
    ) u_wait_counter (
        .clock       (clock),
        .resetb      (resetb),
        .clear       (start_s),
        .in_tw       (in_tw_s),
        .wait_b      (bus.wait_b),
        .forced_done (forced_done_s),
        .timeout_hit (timeout_hit_s)
    );

`ifdef WAIT_TIMEOUT_EN
    logic timeout_r;
    logic timed_out_r;

    // Sticky error flag plus a per-cycle marker that selects the 8'hFF read value.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            timeout_r   <= 1'b0;
            timed_out_r <= 1'b0;
        end else if (start_s) begin
            timed_out_r <= 1'b0;
        end else if (timeout_hit_s) begin
            timed_out_r <= 1'b1;
            timeout_r   <= 1'b1;
        end
    end

    assign timed_out_s = timed_out_r;
    assign bus.timeout = timeout_r;
`else
    assign timed_out_s = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    // Read data value captured when leaving T3.
    always_comb begin
        rd_val_s = bus.d_in;
        if (timed_out_s) begin
            rd_val_s = 8'hFF;
        end else begin
            rd_val_s = bus.d_in;
        end
    end

    // T-state sequencing; TW always occurs at least once.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.req) state_nx_s = ST_T1;
                else         state_nx_s = ST_IDLE;
            end
            ST_T1:   state_nx_s = ST_T2;
            ST_T2:   state_nx_s = ST_TW;
            ST_TW: begin
                if (timeout_hit_s || (bus.wait_b && forced_done_s)) state_nx_s = ST_T3;
                else                                              state_nx_s = ST_TW;
            end
            ST_T3: begin
                if (bus.req) state_nx_s = ST_T1;
                else         state_nx_s = ST_IDLE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State and registered bus/host outputs; strobes fall entering T2 and rise leaving T3.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_r  <= ST_IDLE;
            rnw_r    <= 1'b0;
            a_r      <= 16'h0000;
            d_out_r  <= 8'h00;
            d_oe_r   <= 1'b0;
            iorq_b_r <= 1'b1;
            rd_b_r   <= 1'b1;
            wr_b_r   <= 1'b1;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            rdata_r  <= 8'h00;
        end else begin
            state_r <= state_nx_s;
            done_r  <= (state_r == ST_T3);
            if (start_s) begin
                a_r     <= bus.addr;
                d_out_r <= bus.wdata;
                d_oe_r  <= ~bus.rnw;
                rnw_r   <= bus.rnw;
                busy_r  <= 1'b1;
            end
            case (state_r)
                ST_T1: begin
                    iorq_b_r <= 1'b0;
                    rd_b_r   <= ~rnw_r;
                    wr_b_r   <= rnw_r;
                end
                ST_T3: begin
                    iorq_b_r <= 1'b1;
                    rd_b_r   <= 1'b1;
                    wr_b_r   <= 1'b1;
                    if (rnw_r) begin
                        rdata_r <= rd_val_s;
                    end
                    if (!start_s) begin
                        d_oe_r <= 1'b0;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    iorq_b_r <= iorq_b_r;
                end
            endcase
        end
    end

    assign bus.a      = a_r;
    assign bus.d_out  = d_out_r;
    assign bus.d_oe   = d_oe_r;
    assign bus.iorq_b = iorq_b_r;
    assign bus.rd_b   = rd_b_r;
    assign bus.wr_b   = wr_b_r;
    assign bus.mreq_b = 1'b1;
    assign bus.m1_b   = 1'b1;
    assign bus.done   = done_r;
    assign bus.busy   = busy_r;
    assign bus.rdata  = rdata_r;

endmodule

// File: tb/tb_z80_io_cycle_master.sv
// Bench for z80_io_cycle_master: two instances (EXTRA_WAIT 0 and 2) driven by
// directed transactions. The expected bus timeline is derived from each
// transaction's start cycle and length (4 + EXTRA_WAIT + external waits).
module tb_z80_io_cycle_master;
    import z80_bus_pkg::*;

    localparam int WM = 4;

    typedef struct {
        int          inst;
        int          s;
        int          len;
        bit          rnw;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rd;
        bit          to;
    } txn_t;

    logic clock = 1'b0;
    logic resetb = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    txn_t txq[$];

    int wr_low[2], rd_low[2], iorq_low[2], doe_hi[2], busy_hi[2];
    int done_cnt[2], last_done[2], prev_done[2];

    z80_io_cycle_master_if bus0 ();
    z80_io_cycle_master_if bus1 ();

    z80_io_cycle_master #(.EXTRA_WAIT(0), .WAIT_MAX(WM), .CNT_W(8)) dut0 (
        .clock(clock), .resetb(resetb), .bus(bus0));
    z80_io_cycle_master #(.EXTRA_WAIT(2), .WAIT_MAX(WM), .CNT_W(8)) dut1 (
        .clock(clock), .resetb(resetb), .bus(bus1));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc=%0d got=%h expected=%h", name, inst, cyc, act, exp);
        end
    endtask

    task automatic set_in(input int i, input logic rq, input logic rw, input logic [15:0] ad,
                          input logic [7:0] wd, input logic [7:0] di);
        if (i == 0) begin
            bus0.req = rq; bus0.rnw = rw; bus0.addr = ad; bus0.wdata = wd; bus0.d_in = di;
        end else begin
            bus1.req = rq; bus1.rnw = rw; bus1.addr = ad; bus1.wdata = wd; bus1.d_in = di;
        end
    endtask

    task automatic set_req(input int i, input logic v);
        if (i == 0) bus0.req = v; else bus1.req = v;
    endtask

    task automatic set_wait(input int i, input logic v);
        if (i == 0) bus0.wait_b = v; else bus1.wait_b = v;
    endtask

    task automatic clr_mon(input int i);
        wr_low[i] = 0; rd_low[i] = 0; iorq_low[i] = 0; doe_hi[i] = 0; busy_hi[i] = 0;
        done_cnt[i] = 0; last_done[i] = -1; prev_done[i] = -1;
    endtask

    // Queue a transaction and drive it; called at a negedge when the instance is
    // idle or in T3, returns at the negedge inside its T3 cycle.
    task automatic run_txn(input int i, input bit rw, input logic [15:0] ad, input logic [7:0] wd,
                           input logic [7:0] di, input int w, output int s);
        txn_t t;
        int   e;
        e = (i == 0) ? 0 : 2;
        set_in(i, 1'b1, rw, ad, wd, di);
        s = cyc + 1;
        t.inst = i; t.s = s; t.rnw = rw; t.addr = ad; t.wdata = wd; t.to = 1'b0;
        t.len = 4 + e + w;
`ifdef WAIT_TIMEOUT_EN
        if (w >= WM) begin
            t.len = 3 + WM;
            t.to  = 1'b1;
        end
`endif
        t.rd = t.to ? 8'hFF : di;
        txq.push_back(t);
        @(negedge clock);
        set_req(i, 1'b0);
        if (w > 0) begin
            set_wait(i, 1'b0);
            while (cyc < s + 2 + w) @(negedge clock);
            set_wait(i, 1'b1);
        end
        while (cyc < s + t.len - 1) @(negedge clock);
    endtask

    // Compare process: expected outputs from the transaction timeline, every cycle.
    initial begin
        txn_t        t;
        int          best_s, best_rs;
        logic        e_busy, e_iorq, e_rd, e_wr, e_doe, e_done, e_to;
        logic [15:0] e_a;
        logic [7:0]  e_dout, e_rdata;
        logic        g_busy, g_iorq, g_rd, g_wr, g_doe, g_done, g_to, g_mreq, g_m1;
        logic [15:0] g_a;
        logic [7:0]  g_dout, g_rdata;
        forever begin
            @(negedge clock);
            if (resetb) begin
                for (int i = 0; i < 2; i++) begin
                    e_busy = 1'b0; e_iorq = 1'b1; e_rd = 1'b1; e_wr = 1'b1; e_doe = 1'b0;
                    e_done = 1'b0; e_to = 1'b0; e_a = 16'h0000; e_dout = 8'h00; e_rdata = 8'h00;
                    best_s = -1; best_rs = -1;
                    foreach (txq[j]) begin
                        t = txq[j];
                        if (t.inst == i && t.s <= cyc) begin
                            if (t.s > best_s) begin
                                best_s = t.s; e_a = t.addr; e_dout = t.wdata;
                            end
                            if (cyc <= t.s + t.len - 1) begin
                                e_busy = 1'b1;
                                e_doe  = !t.rnw;
                                if (cyc >= t.s + 1) begin
                                    e_iorq = 1'b0;
                                    if (t.rnw) e_rd = 1'b0; else e_wr = 1'b0;
                                end
                            end
                            if (cyc == t.s + t.len) e_done = 1'b1;
                            if (t.rnw && cyc >= t.s + t.len && t.s > best_rs) begin
                                best_rs = t.s; e_rdata = t.rd;
                            end
                            if (t.to && cyc >= t.s + t.len - 1) e_to = 1'b1;
                        end
                    end
                    if (i == 0) begin
                        g_busy = bus0.busy; g_iorq = bus0.iorq_b; g_rd = bus0.rd_b; g_wr = bus0.wr_b;
                        g_doe = bus0.d_oe; g_done = bus0.done; g_to = bus0.timeout; g_a = bus0.a;
                        g_dout = bus0.d_out; g_rdata = bus0.rdata; g_mreq = bus0.mreq_b; g_m1 = bus0.m1_b;
                    end else begin
                        g_busy = bus1.busy; g_iorq = bus1.iorq_b; g_rd = bus1.rd_b; g_wr = bus1.wr_b;
                        g_doe = bus1.d_oe; g_done = bus1.done; g_to = bus1.timeout; g_a = bus1.a;
                        g_dout = bus1.d_out; g_rdata = bus1.rdata; g_mreq = bus1.mreq_b; g_m1 = bus1.m1_b;
                    end
                    check("busy", i, 32'(g_busy), 32'(e_busy));
                    check("iorq_b", i, 32'(g_iorq), 32'(e_iorq));
                    check("rd_b", i, 32'(g_rd), 32'(e_rd));
                    check("wr_b", i, 32'(g_wr), 32'(e_wr));
                    check("d_oe", i, 32'(g_doe), 32'(e_doe));
                    check("done", i, 32'(g_done), 32'(e_done));
                    check("timeout", i, 32'(g_to), 32'(e_to));
                    check("a", i, 32'(g_a), 32'(e_a));
                    check("d_out", i, 32'(g_dout), 32'(e_dout));
                    check("rdata", i, 32'(g_rdata), 32'(e_rdata));
                    check("mreq_m1", i, 32'({g_mreq, g_m1}), 32'd3);
                    if (!g_wr)   wr_low[i]++;
                    if (!g_rd)   rd_low[i]++;
                    if (!g_iorq) iorq_low[i]++;
                    if (g_doe)   doe_hi[i]++;
                    if (g_busy)  busy_hi[i]++;
                    if (g_done) begin
                        done_cnt[i]++; prev_done[i] = last_done[i]; last_done[i] = cyc;
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s, s2;
        set_in(0, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
        set_in(1, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
        set_wait(0, 1'b1);
        set_wait(1, 1'b1);
        clr_mon(0);
        clr_mon(1);
        repeat (3) @(negedge clock);
        check("reset_iorq", 0, 32'(bus0.iorq_b), 32'd1);
        check("reset_busy", 0, 32'(bus0.busy), 32'd0);
        resetb = 1'b1;
        repeat (2) @(negedge clock);

        // OUT 7F00,C4 with no waits
        clr_mon(0);
        run_txn(0, 1'b0, GA_PORT, 8'hC4, 8'h00, 0, s);
        repeat (2) @(negedge clock);
        check("t1_done_lat", 0, 32'(last_done[0] - s), 32'd4);
        check("t1_wr_low", 0, 32'(wr_low[0]), 32'd3);
        check("t1_iorq_low", 0, 32'(iorq_low[0]), 32'd3);
        check("t1_doe_hi", 0, 32'(doe_hi[0]), 32'd4);
        check("t1_a", 0, 32'(bus0.a), 32'h7F00);
        check("t1_bank_prefix", 0, 32'(bus0.d_out[7:6]), 32'(RAM_BANK_PREFIX));
        check("t1_bank_cfg", 0, 32'(bus0.d_out[2:0]), 32'd4);

        // IN FEFE with three external waits
        clr_mon(0);
        run_txn(0, 1'b1, 16'hFEFE, 8'h00, 8'h5A, 3, s);
        repeat (2) @(negedge clock);
        check("t2_done_lat", 0, 32'(last_done[0] - s), 32'd7);
        check("t2_rd_low", 0, 32'(rd_low[0]), 32'd6);
        check("t2_wr_low", 0, 32'(wr_low[0]), 32'd0);
        check("t2_rdata", 0, 32'(bus0.rdata), 32'h5A);

        // Back-to-back writes
        clr_mon(0);
        run_txn(0, 1'b0, GA_PORT, 8'hC0, 8'h00, 0, s);
        run_txn(0, 1'b0, GA_PORT, 8'hC7, 8'h00, 0, s2);
        repeat (2) @(negedge clock);
        check("t3_done_cnt", 0, 32'(done_cnt[0]), 32'd2);
        check("t3_done_gap", 0, 32'(last_done[0] - prev_done[0]), 32'd4);
        check("t3_wr_low", 0, 32'(wr_low[0]), 32'd6);
        check("t3_doe_hi", 0, 32'(doe_hi[0]), 32'd8);
        check("t3_dout", 0, 32'(bus0.d_out), 32'hC7);

        // EXTRA_WAIT=2 instance
        clr_mon(1);
        run_txn(1, 1'b0, GA_PORT, 8'hC1, 8'h00, 0, s);
        repeat (2) @(negedge clock);
        check("t6_done_lat", 1, 32'(last_done[1] - s), 32'd6);
        check("t6_iorq_low", 1, 32'(iorq_low[1]), 32'd5);
        check("t6_busy_hi", 1, 32'(busy_hi[1]), 32'd6);

`ifdef WAIT_TIMEOUT_EN
        // wait_b held low: timeout after WAIT_MAX samples
        clr_mon(0);
        run_txn(0, 1'b1, 16'hFEFE, 8'h00, 8'h33, WM, s);
        repeat (2) @(negedge clock);
        check("t5_done_lat", 0, 32'(last_done[0] - s), 32'd7);
        check("t5_done_cnt", 0, 32'(done_cnt[0]), 32'd1);
        check("t5_timeout", 0, 32'(bus0.timeout), 32'd1);
        check("t5_rdata", 0, 32'(bus0.rdata), 32'hFF);
`endif

        // Reset during TW of a write
        clr_mon(0);
        begin
            txn_t t;
            set_in(0, 1'b1, 1'b0, GA_PORT, 8'hC2, 8'h00);
            s = cyc + 1;
            t.inst = 0; t.s = s; t.len = 7; t.rnw = 1'b0; t.addr = GA_PORT;
            t.wdata = 8'hC2; t.rd = 8'h00; t.to = 1'b0;
            txq.push_back(t);
        end
        @(negedge clock);
        set_req(0, 1'b0);
        set_wait(0, 1'b0);
        @(negedge clock);
        @(negedge clock);
        check("t4_pre_wr", 0, 32'(bus0.wr_b), 32'd0);
        #2;
        resetb = 1'b0;
        txq.delete();
        #1;
        check("t4_iorq", 0, 32'(bus0.iorq_b), 32'd1);
        check("t4_wr", 0, 32'(bus0.wr_b), 32'd1);
        check("t4_rd", 0, 32'(bus0.rd_b), 32'd1);
        check("t4_doe", 0, 32'(bus0.d_oe), 32'd0);
        check("t4_busy", 0, 32'(bus0.busy), 32'd0);
        set_wait(0, 1'b1);
        @(negedge clock);
        resetb = 1'b1;
        repeat (3) @(negedge clock);
        check("t4_post_busy", 0, 32'(bus0.busy), 32'd0);
        check("t4_no_done", 0, 32'(done_cnt[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
